pb_direction_ctrl: RTL and testbench

//   Upstream stage of the on-screen square mover. Synchronises and debounces the

---
 rtl/pb_ctrl_pkg.sv | 36 +++
 rtl/pb_debounce.sv | 48 ++++
 rtl/pb_direction_ctrl.sv | 84 ++++++++
 tb/tb_pb_direction_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_ctrl_pkg.sv
// Shared constants and helpers for the pushbutton direction controller.
// Directions are one-hot: [0]=up [1]=down [2]=left [3]=right, 0 = stopped.
package pb_ctrl_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // Opposite of a one-hot direction; anything not
  // one-hot maps to DIR_NONE so it never matches a press.
  function automatic logic [3:0] opposite(
    input logic [3:0] d
  );
    logic [3:0] r;
    r = DIR_NONE;
    case (d)
      DIR_UP:    r = DIR_DOWN;
      DIR_DOWN:  r = DIR_UP;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_RIGHT: r = DIR_LEFT;
      default:   r = DIR_NONE;
    endcase
    return r;
  endfunction

  // Isolate the lowest set bit: up wins over down,
  // down over left, left over right.
  function automatic logic [3:0] lowest_one_hot(
    input logic [3:0] v
  );
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// One pushbutton: 2-FF synchroniser, stable-count debouncer and press pulse.
// Ports: clk, reset (sync, active-high), raw in; level, press out.
module pb_debounce
  import pb_ctrl_pkg::*;
#(
  parameter int N = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        // Any agreeing cycle discards progress, so
        // glitches shorter than N never get through.
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/pb_direction_ctrl.sv
// Debounces four buttons, latches the latest press as a one-hot direction,
// and divides the clock into a movement step strobe.
// Ports: clock_25Mhz, reset (sync, active-high), pb_raw[3:0], enable in;
//        pb_level[3:0], pb_press[3:0], dir[3:0], step_tick out.
// Build option: REVERSE_STOP_EN makes a press opposite to dir stop the mover.
module pb_direction_ctrl
  import pb_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TICK_DIV        = 833333
) (
  input  logic       clock_25Mhz,
  input  logic       reset,
  input  logic [3:0] pb_raw,
  input  logic       enable,
  output logic [3:0] pb_level,
  output logic [3:0] pb_press,
  output logic [3:0] dir,
  output logic       step_tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TONE  = TW'(1);

  logic [3:0]    win;
  logic          moving;
  logic [TW-1:0] tcnt;

  for (genvar i = 0; i < 4; i++) begin : g_db
    pb_debounce #(
      .N(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clock_25Mhz),
      .reset(reset),
      .raw  (pb_raw[i]),
      .level(pb_level[i]),
      .press(pb_press[i])
    );
  end

  assign win    = lowest_one_hot(pb_press);
  assign moving = enable && (dir != DIR_NONE);

  // Direction latch: only presses matter, releases
  // leave dir alone; disable clears and forgets.
  always_ff @(posedge clock_25Mhz) begin
    if (reset) begin
      dir <= DIR_NONE;
    end else if (!enable) begin
      dir <= DIR_NONE;
    end else if (pb_press != 4'b0000) begin
`ifdef REVERSE_STOP_EN
      if (win == opposite(dir)) begin
        dir <= DIR_NONE;
      end else begin
        dir <= win;
      end
`else
      dir <= win;
`endif
    end
  end

  // Step divider: free-runs while moving, so a
  // turn keeps the current phase.
  always_ff @(posedge clock_25Mhz) begin
    if (reset) begin
      tcnt      <= '0;
      step_tick <= 1'b0;
    end else if (!moving) begin
      tcnt      <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= (tcnt == TLAST);
      if (tcnt == TLAST) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TONE;
      end
    end
  end

endmodule

// File: tb/tb_pb_direction_ctrl.sv
// Directed bench for pb_direction_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Honours REVERSE_STOP_EN for the expected reverse-press behaviour.
module tb_pb_direction_ctrl;

  localparam int DB = 4;
  localparam int TD = 5;

`ifdef REVERSE_STOP_EN
  localparam logic [3:0] T4B   = 4'b0001;
  localparam logic [3:0] T6DIR = 4'b0000;
`else
  localparam logic [3:0] T4B   = 4'b0100;
  localparam logic [3:0] T6DIR = 4'b0010;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] pb_raw;
  logic       enable;
  logic [3:0] pb_level;
  logic [3:0] pb_press;
  logic [3:0] dir;
  logic       step_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pb_direction_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (TD)
  ) dut (
    .clock_25Mhz(clk),
    .reset      (reset),
    .pb_raw     (pb_raw),
    .enable     (enable),
    .pb_level   (pb_level),
    .pb_press   (pb_press),
    .dir        (dir),
    .step_tick  (step_tick)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] dr;
    logic       tk;
  } vec_t;

  vec_t vt[16];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Advance n cycles, requiring no press pulse throughout.
  task automatic quiet(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk(nm, pb_press, 4'h0);
    end
  endtask

  initial begin
    // rst en raw | level press dir tick
    vt[0]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};
    vt[10] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};
    vt[11] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};
    vt[12] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};
    vt[14] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b1};
    vt[15] = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h1, 1'b0};

    reset  = 1'b1;
    enable = 1'b1;
    pb_raw = 4'hF;

    // 1: reset state, all-press priority, first tick
    for (int i = 0; i < 16; i++) begin
      reset  = vt[i].rst;
      enable = vt[i].en;
      pb_raw = vt[i].raw;
      cyc();
      chk($sformatf("v%0d_level", i), pb_level, vt[i].lvl);
      chk($sformatf("v%0d_press", i), pb_press, vt[i].prs);
      chk($sformatf("v%0d_dir", i), dir, vt[i].dr);
      chk($sformatf("v%0d_tick", i), {3'b0, step_tick},
          {3'b0, vt[i].tk});
    end

    // 2: releases keep dir, then a bouncing up press
    pb_raw = 4'h0;
    quiet(6, "t2_rel_press");
    chk("t2_rel_level", pb_level, 4'h0);
    chk("t2_rel_dir", dir, 4'h1);
    enable = 1'b0;
    cyc();
    chk("t2_dis_dir", dir, 4'h0);
    enable = 1'b1;
    cyc();
    chk("t2_en_dir", dir, 4'h0);
    pb_raw = 4'h1; quiet(1, "t2_bounce");
    pb_raw = 4'h0; quiet(1, "t2_bounce");
    pb_raw = 4'h1; quiet(1, "t2_bounce");
    pb_raw = 4'h0; quiet(1, "t2_bounce");
    pb_raw = 4'h1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("t2_settle_press", pb_press, 4'h0);
      chk("t2_settle_level", pb_level, 4'h0);
    end
    cyc();
    chk("t2_level", pb_level, 4'h1);
    chk("t2_press", pb_press, 4'h1);
    cyc();
    chk("t2_press_end", pb_press, 4'h0);
    chk("t2_dir", dir, 4'h1);

    // 3: left and right together, left wins
    pb_raw = 4'h0;
    quiet(7, "t3_rel_press");
    pb_raw = 4'b1100;
    quiet(5, "t3_wait_press");
    cyc();
    chk("t3_press", pb_press, 4'b1100);
    cyc();
    chk("t3_press_end", pb_press, 4'h0);
    chk("t3_dir", dir, 4'b0100);

    // 4: ticks keep phase across a turn
    pb_raw = 4'h0;
    quiet(7, "t4_rel_press");
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    pb_raw = 4'b1000;
    quiet(5, "t4_wait_press");
    cyc();
    chk("t4_press", pb_press, 4'b1000);
    cyc();
    chk("t4_dir", dir, 4'b1000);
    for (int k = 1; k <= 16; k++) begin
      if (k == 2) pb_raw = 4'b1000 | T4B;
      cyc();
      chk($sformatf("t4_tick_c%0d", k), {3'b0, step_tick},
          {3'b0, (k % 5) == 0});
      if (k == 7) chk("t4_turn_press", pb_press, T4B);
      if (k == 8) chk("t4_turn_dir", dir, T4B);
    end

    // 5: disable clears dir and forgets presses
    pb_raw = 4'h0;
    quiet(7, "t5_rel_press");
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    pb_raw = 4'h1;
    quiet(5, "t5_wait_press");
    cyc();
    chk("t5_press", pb_press, 4'h1);
    cyc();
    chk("t5_dir_up", dir, 4'h1);
    enable = 1'b0;
    cyc();
    chk("t5_dis_dir", dir, 4'h0);
    chk("t5_dis_tick", {3'b0, step_tick}, 4'h0);
    pb_raw = 4'b1001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("t5_dis_tick", {3'b0, step_tick}, 4'h0);
    end
    chk("t5_dis_press", pb_press, 4'b1000);
    cyc();
    chk("t5_dis_dir2", dir, 4'h0);
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t5_en_dir", dir, 4'h0);
      chk("t5_en_tick", {3'b0, step_tick}, 4'h0);
    end

    // 6: opposite press, then reset mid-debounce
    pb_raw = 4'b1000;
    quiet(7, "t6_rel_press");
    pb_raw = 4'b1001;
    quiet(5, "t6_wait_up");
    cyc();
    chk("t6_press_up", pb_press, 4'h1);
    cyc();
    chk("t6_dir_up", dir, 4'h1);
    pb_raw = 4'b1011;
    quiet(5, "t6_wait_down");
    cyc();
    chk("t6_press_down", pb_press, 4'b0010);
    cyc();
    chk("t6_dir_rev", dir, T6DIR);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("t6_dir_hold", dir, T6DIR);
`ifdef REVERSE_STOP_EN
      chk("t6_stop_tick", {3'b0, step_tick}, 4'h0);
`endif
    end
    pb_raw = 4'h0;
    quiet(7, "t6_rel_press");
    chk("t6_rel_level", pb_level, 4'h0);
    pb_raw = 4'b0010;
    quiet(4, "t6_pre_rst");
    reset = 1'b1;
    cyc();
    chk("t6_rst_level", pb_level, 4'h0);
    chk("t6_rst_press", pb_press, 4'h0);
    chk("t6_rst_dir", dir, 4'h0);
    chk("t6_rst_tick", {3'b0, step_tick}, 4'h0);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("t6_restart_c%0d", k), pb_level,
          (k == 6) ? 4'b0010 : 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
